// File: rtl/uart_matrix_pkg.sv
// Shared types and constants for the UART matrix engine.
// State and op encodings plus an index-width helper.
package uart_matrix_pkg;

  typedef enum logic [1:0] {
    ST_LOAD_A  = 2'd0,
    ST_LOAD_B  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_SEND    = 2'd3
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_matrix_engine_mac_unit.sv
// Registered single-cycle unsigned multiply-accumulate.
// clear with enable restarts the sum at the current product.
module matrix_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] prod;

  assign prod  = ACC_W'(a_i) * ACC_W'(b_i);
  assign acc_o = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (enable_i) begin
      acc_q <= (clear_i ? '0 : acc_q) + prod;
    end else if (clear_i) begin
      acc_q <= '0;
    end
  end

endmodule

// File: rtl/uart_matrix_engine.sv
// NxN byte-matrix engine between UART rx and tx: loads A and B, computes A*B or A+B.
// Define UART_MATRIX_CHECKSUM_EN to append an XOR checksum byte after the result.
module uart_matrix_engine
  import uart_matrix_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+$clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              op_sel,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_valid,
  input  logic              tx_ack,
  output logic              busy,
  output logic [1:0]        state_o,
  output logic              overrun,
  output logic              done
);

  localparam int NN = N*N;
`ifdef UART_MATRIX_CHECKSUM_EN
  localparam int NOUT = NN+1;
`else
  localparam int NOUT = NN;
`endif
  localparam int AW = idx_w(NN);
  localparam int OW = idx_w(NOUT);
  localparam int KW = idx_w(N);

  localparam logic [AW-1:0] LAST_IX = AW'(NN-1);
  localparam logic [OW-1:0] LAST_OX = OW'(NOUT-1);
  localparam logic [KW-1:0] LAST_K  = KW'(N-1);

  state_e            state_q;
  logic [DATA_W-1:0] a_q [NN];
  logic [DATA_W-1:0] b_q [NN];
  logic [DATA_W-1:0] r_q [NN];
  logic [AW-1:0]     idx_q;
  logic [AW-1:0]     wr_ix_q;
  logic [OW-1:0]     ox_q;
  logic [KW-1:0]     row_q;
  logic [KW-1:0]     col_q;
  logic [KW-1:0]     k_q;
  logic              op_q;
  logic              wr_pend_q;
  logic              tx_valid_q;
  logic [DATA_W-1:0] tx_byte_q;
  logic              busy_q;
  logic              overrun_q;
  logic              done_q;
`ifdef UART_MATRIX_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  logic [AW-1:0]     a_ix;
  logic [AW-1:0]     b_ix;
  logic [AW-1:0]     e_ix;
  logic [OW-1:0]     nx_ox;
  logic [DATA_W-1:0] nx_byte;
  logic [DATA_W-1:0] sum_add;
  logic              mac_en;
  logic              mac_clr;
  logic              elem_step;
  logic [ACC_W-1:0]  acc;
  logic              unused_acc_hi;

  assign a_ix  = AW'(row_q) * AW'(N) + AW'(k_q);
  assign b_ix  = AW'(k_q) * AW'(N) + AW'(col_q);
  assign e_ix  = AW'(row_q) * AW'(N) + AW'(col_q);
  assign nx_ox = ox_q + OW'(1);

  assign sum_add   = a_q[e_ix] + b_q[e_ix];
  assign mac_en    = (state_q == ST_COMPUTE) && (op_q == OP_MUL);
  assign mac_clr   = (k_q == '0);
  assign elem_step = (op_q == OP_ADD) || (k_q == LAST_K);

  assign unused_acc_hi = ^acc[ACC_W-1:DATA_W];

  always_comb begin
    nx_byte = '0;
    if (int'(nx_ox) < NN) nx_byte = r_q[AW'(nx_ox)];
`ifdef UART_MATRIX_CHECKSUM_EN
    else nx_byte = csum_q;
`endif
  end

  matrix_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (mac_clr),
    .enable_i (mac_en),
    .a_i      (a_q[a_ix]),
    .b_i      (b_q[b_ix]),
    .acc_o    (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD_A;
      a_q        <= '{default: '0};
      b_q        <= '{default: '0};
      r_q        <= '{default: '0};
      idx_q      <= '0;
      wr_ix_q    <= '0;
      ox_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      op_q       <= OP_MUL;
      wr_pend_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_MATRIX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      wr_pend_q <= 1'b0;
      // MAC result lands one cycle after its last term
      if (wr_pend_q) begin
        r_q[wr_ix_q] <= acc[DATA_W-1:0];
`ifdef UART_MATRIX_CHECKSUM_EN
        csum_q <= csum_q ^ acc[DATA_W-1:0];
`endif
      end
      unique case (state_q)
        ST_LOAD_A: begin
          if (rx_valid) begin
            a_q[idx_q] <= rx_byte;
            if (idx_q == '0) op_q <= op_sel;
            if (idx_q == LAST_IX) begin
              idx_q   <= '0;
              state_q <= ST_LOAD_B;
            end else begin
              idx_q <= idx_q + AW'(1);
            end
          end
        end
        ST_LOAD_B: begin
          if (rx_valid) begin
            b_q[idx_q] <= rx_byte;
            if (idx_q == LAST_IX) begin
              idx_q   <= '0;
              row_q   <= '0;
              col_q   <= '0;
              k_q     <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_COMPUTE;
`ifdef UART_MATRIX_CHECKSUM_EN
              csum_q  <= '0;
`endif
            end else begin
              idx_q <= idx_q + AW'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (rx_valid) overrun_q <= 1'b1;
          if (op_q == OP_ADD) begin
            r_q[e_ix] <= sum_add;
`ifdef UART_MATRIX_CHECKSUM_EN
            csum_q <= csum_q ^ sum_add;
`endif
          end else if (k_q == LAST_K) begin
            k_q       <= '0;
            wr_pend_q <= 1'b1;
            wr_ix_q   <= e_ix;
          end else begin
            k_q <= k_q + KW'(1);
          end
          if (elem_step) begin
            if (col_q == LAST_K) begin
              col_q <= '0;
              if (row_q == LAST_K) begin
                row_q   <= '0;
                state_q <= ST_SEND;
              end else begin
                row_q <= row_q + KW'(1);
              end
            end else begin
              col_q <= col_q + KW'(1);
            end
          end
        end
        ST_SEND: begin
          if (rx_valid) overrun_q <= 1'b1;
          // tx_valid is low in SEND only on the entry cycle
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_byte_q  <= r_q[0];
            ox_q       <= '0;
          end else if (tx_ack) begin
            if (ox_q == LAST_OX) begin
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              ox_q       <= '0;
              state_q    <= ST_LOAD_A;
            end else begin
              ox_q      <= nx_ox;
              tx_byte_q <= nx_byte;
            end
          end
        end
      endcase
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign state_o  = state_q;
  assign overrun  = overrun_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_matrix_engine.sv
// Self-checking bench for uart_matrix_engine against a plain-arithmetic matrix model.
// Covers reset, multiply, wrap, add, back-pressure, overrun and mid-operation reset.
module tb_uart_matrix_engine;

  localparam int N  = 3;
  localparam int NN = N*N;
`ifdef UART_MATRIX_CHECKSUM_EN
  localparam int NOUT = NN+1;
`else
  localparam int NOUT = NN;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       op_sel;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ack;
  logic       busy;
  logic [1:0] state_o;
  logic       overrun;
  logic       done;

  always #5 clk = ~clk;

  uart_matrix_engine #(.N(N), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .op_sel   (op_sel),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ack   (tx_ack),
    .busy     (busy),
    .state_o  (state_o),
    .overrun  (overrun),
    .done     (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int ma [NN];
  int mb [NN];
  int exp_q [$];
  int got_q [$];
  int lat;
  int done_cnt;
  bit unstable;
  logic done_last;
  logic done_extra;
  logic tv_after;
  logic [1:0] st_after;

  function automatic void build_expected(input bit op);
    int s;
    int v;
    int x;
    exp_q.delete();
    x = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (op) begin
          v = (ma[r*N+c] + mb[r*N+c]) % 256;
        end else begin
          s = 0;
          for (int k = 0; k < N; k++) s += ma[r*N+k] * mb[k*N+c];
          v = s % 256;
        end
        exp_q.push_back(v);
        x = x ^ v;
      end
    end
`ifdef UART_MATRIX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = '0;
    op_sel   = 1'b0;
    tx_ack   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input int b, input bit op);
    rx_byte  = 8'(b);
    op_sel   = op;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic load(input bit op);
    for (int i = 0; i < NN; i++) send_byte(ma[i], op);
    for (int i = 0; i < NN; i++) send_byte(mb[i], op);
  endtask

  task automatic drain(input int hold);
    logic [7:0] b;
    got_q.delete();
    unstable = 1'b0;
    done_cnt = 0;
    lat      = -1;
    for (int i = 0; i < NOUT; i++) begin
      int w;
      w = 0;
      while (tx_valid !== 1'b1 && w < 5000) begin
        @(negedge clk);
        w++;
      end
      if (tx_valid !== 1'b1) break;
      if (i == 0) lat = w;
      b = tx_byte;
      repeat (hold) begin
        @(negedge clk);
        if (tx_valid !== 1'b1 || tx_byte !== b) unstable = 1'b1;
      end
      got_q.push_back(int'(b));
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      if (done === 1'b1) done_cnt++;
    end
    done_last = done;
    tv_after  = tx_valid;
    st_after  = state_o;
    @(negedge clk);
    done_extra = done;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({state_o, tx_valid, busy, overrun, done, tx_byte} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d v=%b busy=%b ovr=%b done=%b byte=%0h want all 0",
               state_o, tx_valid, busy, overrun, done, tx_byte);
    end
  endtask

  task automatic test_identity();
    int bad;
    for (int i = 0; i < NN; i++) begin
      ma[i] = i + 1;
      mb[i] = (i / N == i % N) ? 1 : 0;
    end
    build_expected(1'b0);
    load(1'b0);
    drain(0);
    bad = (got_q.size() != NOUT) ? -2 : -1;
    for (int i = 0; i < got_q.size() && bad == -1; i++)
      if (got_q[i] != exp_q[i]) bad = i;
    n_checks++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL identity_bytes: got %p want %p", got_q, exp_q);
    end
    n_checks++;
    if (lat != N*N*N+1) begin
      n_fail++;
      $display("FAIL identity_latency: got %0d want %0d", lat, N*N*N+1);
    end
    n_checks++;
    if (done_cnt != 1 || done_last !== 1'b1 || done_extra !== 1'b0) begin
      n_fail++;
      $display("FAIL identity_done: got cnt=%0d last=%b next=%b want 1,1,0",
               done_cnt, done_last, done_extra);
    end
    n_checks++;
    if (tv_after !== 1'b0 || st_after !== 2'd0) begin
      n_fail++;
      $display("FAIL identity_return: got v=%b st=%0d want 0,0", tv_after, st_after);
    end
  endtask

  task automatic test_wrap();
    int bad;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < NN; i++) begin
        ma[i] = (t == 0) ? 2 : 255;
        mb[i] = (t == 0) ? 3 : 255;
      end
      build_expected(1'b0);
      load(1'b0);
      drain(0);
      bad = (got_q.size() != NOUT) ? -2 : -1;
      for (int i = 0; i < got_q.size() && bad == -1; i++)
        if (got_q[i] != exp_q[i] || (i < NN && got_q[i] != ((t == 0) ? 8'h12 : 8'h03)))
          bad = i;
      n_checks++;
      if (bad != -1) begin
        n_fail++;
        $display("FAIL wrap_bytes_%0d: got %p want %p", t, got_q, exp_q);
      end
    end
  endtask

  task automatic test_add();
    int bad;
    for (int i = 0; i < NN; i++) begin
      ma[i] = 200;
      mb[i] = 100;
    end
    build_expected(1'b1);
    load(1'b1);
    drain(0);
    bad = (got_q.size() != NOUT) ? -2 : -1;
    for (int i = 0; i < got_q.size() && bad == -1; i++)
      if (got_q[i] != exp_q[i] || (i < NN && got_q[i] != 8'h2C)) bad = i;
    n_checks++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL add_bytes: got %p want %p", got_q, exp_q);
    end
    n_checks++;
    if (lat != N*N+1) begin
      n_fail++;
      $display("FAIL add_latency: got %0d want %0d", lat, N*N+1);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    for (int i = 0; i < NN; i++) begin
      ma[i] = int'($urandom_range(0, 255));
      mb[i] = int'($urandom_range(0, 255));
    end
    build_expected(1'b0);
    load(1'b0);
    drain(50);
    n_checks++;
    if (unstable) begin
      n_fail++;
      $display("FAIL backpressure_stable: got change while ack low, want stable");
    end
    bad = (got_q.size() != NOUT) ? -2 : -1;
    for (int i = 0; i < got_q.size() && bad == -1; i++)
      if (got_q[i] != exp_q[i]) bad = i;
    n_checks++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL backpressure_bytes: got %p want %p", got_q, exp_q);
    end
  endtask

  task automatic test_overrun();
    int bad;
    for (int i = 0; i < NN; i++) begin
      ma[i] = int'($urandom_range(0, 255));
      mb[i] = int'($urandom_range(0, 255));
    end
    build_expected(1'b0);
    load(1'b0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || state_o !== 2'd2) begin
      n_fail++;
      $display("FAIL compute_busy: got busy=%b st=%0d want 1,2", busy, state_o);
    end
    send_byte(8'hAA, 1'b1);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    drain(0);
    bad = (got_q.size() != NOUT) ? -2 : -1;
    for (int i = 0; i < got_q.size() && bad == -1; i++)
      if (got_q[i] != exp_q[i]) bad = i;
    n_checks++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL overrun_bytes: got %p want %p", got_q, exp_q);
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_flag: got %b want 1", overrun);
    end
    do_reset();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b want 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    for (int i = 0; i < 5; i++) send_byte(i + 77, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_state: got %0d want 0", state_o);
    end
    for (int i = 0; i < NN; i++) begin
      ma[i] = i + 1;
      mb[i] = (i / N == i % N) ? 1 : 0;
    end
    build_expected(1'b0);
    load(1'b0);
    drain(0);
    bad = (got_q.size() != NOUT) ? -2 : -1;
    for (int i = 0; i < got_q.size() && bad == -1; i++)
      if (got_q[i] != exp_q[i]) bad = i;
    n_checks++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL midreset_bytes: got %p want %p", got_q, exp_q);
    end
    load(1'b1);
    repeat (N*N+3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0 || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL sendreset: got v=%b st=%0d want 0,0", tx_valid, state_o);
    end
  endtask

  task automatic test_random();
    int bad;
    bit op;
    for (int t = 0; t < 6; t++) begin
      op = 1'($urandom_range(0, 1));
      for (int i = 0; i < NN; i++) begin
        ma[i] = int'($urandom_range(0, 255));
        mb[i] = int'($urandom_range(0, 255));
      end
      build_expected(op);
      load(op);
      drain(int'($urandom_range(0, 3)));
      bad = (got_q.size() != NOUT) ? -2 : -1;
      for (int i = 0; i < got_q.size() && bad == -1; i++)
        if (got_q[i] != exp_q[i]) bad = i;
      n_checks++;
      if (bad != -1 || lat != (op ? N*N+1 : N*N*N+1)) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d: got %p lat=%0d want %p lat=%0d",
                 t, op, got_q, lat, exp_q, op ? N*N+1 : N*N*N+1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_wrap();
    test_add();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_matrix_engine.md
Name: uart_matrix_engine

Overview:
- Parametrised NxN byte-matrix engine between the UART receiver and the UART transmitter.
- Collects two NxN operand matrices from the receive byte stream and computes A*B or A+B with a serial MAC.
- Streams the NxN result bytes to the transmitter over a valid/ack handshake.
- Generalises the fixed 3x3 multiply-only flow: any N, selectable operation, overrun detection and a done pulse.

Parameters:
- N, 3, matrix dimension, 2..8.
- DATA_W, 8, element and byte width.
- ACC_W, 2*DATA_W+$clog2(N), accumulator width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_valid  in  1  one-cycle strobe: rx_byte holds a received byte
- rx_byte  in  DATA_W  received byte
- op_sel  in  1  0 = multiply, 1 = add; sampled on the first A byte
- tx_byte  out  DATA_W  result byte to transmitter
- tx_valid  out  1  tx_byte valid, held until accepted
- tx_ack  in  1  one-cycle pulse: transmitter accepted tx_byte
- busy  out  1  high in COMPUTE and SEND
- state_o  out  2  current state encoding
- overrun  out  1  sticky; rx_valid seen while busy
- done  out  1  one-cycle pulse after the last result byte is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state LOAD_A, all indices 0, matrices 0, tx_byte 0, tx_valid 0, busy 0, overrun 0, done 0, state_o 0.
- Reset mid-operation discards all partial data and any pending tx byte. tx_valid falls on the reset edge.
- States and encodings: LOAD_A=0, LOAD_B=1, COMPUTE=2, SEND=3.
- LOAD_A:
  - Each rx_valid stores rx_byte at row-major index idx; idx increments.
  - op_sel is latched when idx==0.
  - At idx==N*N-1, idx clears and the state moves to LOAD_B.
- LOAD_B: same as LOAD_A, then moves to COMPUTE.
- COMPUTE, multiply:
  - For each result element (r,c) in row-major order, k runs 0..N-1 at one MAC per cycle: acc += A[r][k]*B[k][c], unsigned.
  - acc clears at k==0. On k==N-1 the low DATA_W bits of the final sum are written to R[r][c].
  - Total N*N*N cycles, then SEND.
- COMPUTE, add: R[r][c] = low DATA_W bits of A+B, one element per cycle, N*N cycles.
- All results truncate (wrap) to DATA_W bits. No saturation.
- SEND:
  - On the cycle after entering SEND, tx_byte=R[0][0] and tx_valid=1.
  - On tx_ack, the output index advances and the next byte is presented in the following cycle. tx_valid stays high between bytes.
  - tx_ack while tx_valid=0 is ignored.
  - After the ack of the last byte: tx_valid=0, done=1 for one cycle, state returns to LOAD_A.
- rx_valid in COMPUTE or SEND: byte dropped, overrun set. Only rst clears overrun.
- rx_valid and tx_ack in the same cycle in SEND: the ack is processed and the byte is dropped with overrun set.
- Latency from last B byte to first tx_valid: multiply N^3+1 cycles, add N^2+1 cycles.

Optional Feature:
- Macro UART_MATRIX_CHECKSUM_EN.
- Defined:
  - After the N*N result bytes, one extra byte is sent: the XOR of all result bytes, using the same handshake.
  - done pulses after the checksum byte is acked.
- Undefined: exactly N*N bytes are sent and no checksum logic exists.

Decomposition:
- Package uart_matrix_pkg holds:
  - state encoding constants ST_LOAD_A, ST_LOAD_B, ST_COMPUTE, ST_SEND;
  - op constants OP_MUL=0, OP_ADD=1;
  - an index-width helper.
- Sub-module matrix_mac_unit:
  - inputs: clear, enable, a, b;
  - output: ACC_W accumulator;
  - registered, single-cycle MAC.
- Top holds storage, counters, the FSM and the tx handshake.

Test Plan:
- Identity: N=3, op_sel=0, A=1..9, B=identity -> tx bytes 1,2,...,9, then done pulse; first tx_valid 28 cycles after the last B strobe.
- Wrap: A all 2, B all 3, op_sel=0 -> nine bytes 0x12. A all 0xFF, B all 0xFF -> each sum is 3*0xFE01=0x2FA03, so nine bytes 0x03.
- Add mode: A all 200, B all 100, op_sel=1 -> nine bytes 0x2C; first tx_valid 10 cycles after the last B strobe.
- Back-pressure: hold tx_ack low for 50 cycles -> tx_byte and tx_valid stable throughout; no byte skipped or duplicated.
- Overrun and reset: inject rx_valid during COMPUTE -> overrun=1 and results unaffected. Assert rst after 5 A bytes -> state_o=0; a new full A/B load gives correct results.
- UART_MATRIX_CHECKSUM_EN: identity case -> ten bytes ending in 0x01 (XOR of 1..9); done after the tenth ack.
